// File: rtl/jfpjc_pkg.sv
// Shared JPEG front-end constants: image geometry, EBR bank layout and the row-reader state set.
// The camera ingester imports the same package so both sides agree on the MCU-to-EBR address mapping.
package jfpjc_pkg;

    localparam int WIDTH_PIX     = 320;
    localparam int HEIGHT_PIX    = 240;
    localparam int NUM_EBR       = 5;
    localparam int EBR_SIZE      = 512;
    localparam int MCU_BYTES     = 64;
    localparam int MCUS_PER_ROW  = WIDTH_PIX / 8;
    localparam int SLOTS_PER_EBR = MCUS_PER_ROW / NUM_EBR;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } row_state_e;

    // MCU m sits in EBR (m mod NUM_EBR) at slot (m / NUM_EBR), 64 bytes per slot.
    function automatic logic [8:0] ebr_addr(input logic [2:0] slot,
                                            input logic [2:0] py,
                                            input logic [2:0] px);
        return {slot, py, px};
    endfunction

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry valid/ready FIFO with a registered head; the producer must only push when a slot
// is free (the row reader's read-credit logic guarantees that).
module sync_fifo2 #(
    parameter int WIDTH = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] tail_r;
    logic [1:0]       count_r;
    logic             pop_s;

    assign pop_s     = (count_r != 2'd0) && out_ready;
    assign out_valid = (count_r != 2'd0);
    assign out_data  = head_r;
    assign count     = count_r;

    // Entry storage and occupancy; head always holds the oldest byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 2'd0;
        end else if (flush) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 2'd0;
        end else begin
            case (count_r)
                2'd0: begin
                    if (in_valid) begin
                        head_r  <= in_data;
                        count_r <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({in_valid, pop_s})
                        2'b11:   head_r <= in_data;
                        2'b10: begin
                            tail_r  <= in_data;
                            count_r <= 2'd2;
                        end
                        2'b01:   count_r <= 2'd0;
                        default: count_r <= count_r;
                    endcase
                end
                2'd2: begin
                    if (pop_s) begin
                        head_r <= tail_r;
                        if (in_valid) begin
                            tail_r <= in_data;
                        end else begin
                            count_r <= 2'd1;
                        end
                    end
                end
                default: count_r <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/mcu_row_reader.sv
// Reads one completed MCU row from the back EBR bank and streams it as 40 MCUs of 64 raster-order
// bytes with first/last/row-last framing; a bank flip mid-row flags a sticky overrun and restarts.
module mcu_row_reader
    import jfpjc_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       frontbuffer_select,
    output logic       ebr_bank_select,
    output logic [2:0] ebr_block_select,
    output logic [8:0] ebr_read_addr,
    output logic       ebr_rden,
    input  logic [7:0] ebr_rdata,
    output logic [7:0] out_pixval,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_mcu_first,
    output logic       out_mcu_last,
    output logic       out_row_last,
    output logic       overrun,
    input  logic       overrun_clear
);

    row_state_e  state_r;
    logic        fb_prev_r;
    logic        bank_r;
    logic [2:0]  px_r;
    logic [2:0]  py_r;
    logic [2:0]  ebr_idx_r;
    logic [2:0]  slot_r;
    logic        rdv_r;
    logic        tag_first_r;
    logic        tag_last_r;
    logic        overrun_r;
    logic [5:0]  mcu_out_r;

    logic        toggle_s;
    logic        pop_s;
    logic        credit_s;
    logic        issue_s;
    logic        last_read_s;
    logic [1:0]  fifo_count_s;
    logic        fifo_valid_s;
    logic [9:0]  fifo_data_s;

    assign toggle_s    = (frontbuffer_select != fb_prev_r);
    assign pop_s       = fifo_valid_s && out_ready;
    // A slot must exist for every read already issued, counting the byte leaving this cycle.
    assign credit_s    = (({1'b0, fifo_count_s} + {2'b00, rdv_r}) < (3'd2 + {2'b00, pop_s}));
    assign issue_s     = (state_r == ST_READ) && credit_s && !toggle_s;
    assign last_read_s = (px_r == 3'd7) && (py_r == 3'd7)
                         && (ebr_idx_r == 3'(NUM_EBR - 1))
                         && (slot_r == 3'(SLOTS_PER_EBR - 1));

    assign ebr_bank_select  = bank_r;
    assign ebr_block_select = ebr_idx_r;
    assign ebr_read_addr    = ebr_addr(slot_r, py_r, px_r);
    assign ebr_rden         = issue_s;
    assign overrun          = overrun_r;
    assign out_valid        = fifo_valid_s;
    assign out_pixval       = fifo_data_s[7:0];
    assign out_mcu_first    = fifo_data_s[9];
    assign out_mcu_last     = fifo_data_s[8];
    assign out_row_last     = fifo_valid_s && fifo_data_s[8]
                              && (mcu_out_r == 6'(MCUS_PER_ROW - 1));

    // Row sequencer: toggle detection, bank latch, read counters, overrun flag and MCU tracking.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            fb_prev_r   <= 1'b0;
            bank_r      <= 1'b0;
            px_r        <= 3'd0;
            py_r        <= 3'd0;
            ebr_idx_r   <= 3'd0;
            slot_r      <= 3'd0;
            rdv_r       <= 1'b0;
            tag_first_r <= 1'b0;
            tag_last_r  <= 1'b0;
            overrun_r   <= 1'b0;
            mcu_out_r   <= 6'd0;
        end else begin
            fb_prev_r <= frontbuffer_select;
            if (toggle_s && (state_r != ST_IDLE)) begin
                overrun_r <= 1'b1;
            end else if (overrun_clear) begin
                overrun_r <= 1'b0;
            end
            if (toggle_s) begin
                state_r   <= ST_READ;
                bank_r    <= ~frontbuffer_select;
                px_r      <= 3'd0;
                py_r      <= 3'd0;
                ebr_idx_r <= 3'd0;
                slot_r    <= 3'd0;
                rdv_r     <= 1'b0;
                mcu_out_r <= 6'd0;
            end else begin
                rdv_r <= issue_s;
                if (issue_s) begin
                    tag_first_r <= (px_r == 3'd0) && (py_r == 3'd0);
                    tag_last_r  <= (px_r == 3'd7) && (py_r == 3'd7);
                    px_r        <= px_r + 3'd1;
                    if (px_r == 3'd7) begin
                        py_r <= py_r + 3'd1;
                        if (py_r == 3'd7) begin
                            if (ebr_idx_r == 3'(NUM_EBR - 1)) begin
                                ebr_idx_r <= 3'd0;
                                slot_r    <= slot_r + 3'd1;
                            end else begin
                                ebr_idx_r <= ebr_idx_r + 3'd1;
                            end
                        end
                    end
                end
                if (pop_s && fifo_data_s[8]) begin
                    mcu_out_r <= mcu_out_r + 6'd1;
                end
                case (state_r)
                    ST_IDLE:  state_r <= ST_IDLE;
                    ST_READ: begin
                        if (issue_s && last_read_s) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if ((fifo_count_s == 2'd0) && !rdv_r) begin
                            state_r <= ST_IDLE;
                        end
                    end
                    default:  state_r <= ST_IDLE;
                endcase
            end
        end
    end

    sync_fifo2 #(.WIDTH(10)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (toggle_s),
        .in_valid  (rdv_r),
        .in_data   ({tag_first_r, tag_last_r, ebr_rdata}),
        .out_valid (fifo_valid_s),
        .out_data  (fifo_data_s),
        .out_ready (out_ready),
        .count     (fifo_count_s)
    );

endmodule
